dilate: RTL and testbench
=========================

# dilate

Binary 3x3 morphological dilation on the 1-bit mask stream that the median/erode filter chain produces. It sits directly downstream of the erode stage, on the same `de`/`data` pixel-stream interface. Together the two stages form a morphological opening that restores blob size before face-region extraction. Input is one raster frame of U_COL x U_ROW beats; output is the same number of beats, in raster order, delayed.

## Interface
- U_COL, 1280, pixels per line (>= 4)
- U_ROW, 720, lines per frame (>= 3)

- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset; one clock
- in_de  in  1  input beat valid; one mask pixel per asserted cycle
- in_data  in  1  input mask pixel (1 = foreground)
- out_de  out  1  output beat valid
- out_data  out  1  dilated pixel; valid only with out_de
- err  out  1  one-cycle pulse: input beat dropped during FLUSH

## Operation
- Window and output value:
  - Output pixel (r,c) = OR of input pixels (r-1..r+1, c-1..c+1).
  - Neighbours outside the frame contribute 0; there is no padding replication.
- No wrap across lines: the right neighbour of column U_COL-1 and the left neighbour of column 0 are masked to 0. The mask is driven from the centre column counter, not the input column.
- Storage:
  - Two 1-bit line buffers of depth U_COL: previous row and row before previous.
  - A 3x3 shift window fed from the line buffers.
  - Storage advances only on accepted beats.
  - Line buffers are not cleared on reset; row-0 masking makes stale contents irrelevant.
- Counters:
  - col: width $clog2(U_COL); wraps U_COL-1 -> 0 and increments row.
  - row: width $clog2(U_ROW).
  - flush: width $clog2(U_COL+2).
- State machine:
  - IDLE: counters at 0. First in_de -> accept pixel (0,0), go to STREAM.
  - STREAM: every in_de is accepted. Accepting pixel (U_ROW-1, U_COL-1) -> FLUSH.
  - FLUSH: inject U_COL+1 virtual zero beats, one per cycle, regardless of in_de. After the last virtual beat -> IDLE.
- Flush-time input: in_de during FLUSH is dropped and err pulses on the next cycle. The beat is not counted, and the flush continues.
- Output ordering: output beat k (raster index) is produced by accepted or virtual beat k+U_COL+1. Beats 0..U_COL of the input stream produce no output.
- Frame totals: exactly U_COL*U_ROW out_de pulses per frame.
- Reset mid-frame:
  - State -> IDLE; counters 0; pipeline valid bits 0.
  - The next in_de is treated as pixel (0,0) of a new frame.

## Timing
- Reset values: out_de=0, out_data=0, err=0, state IDLE, all counters 0.
- Latency:
  - out_de/out_data register 2 cycles after the producing beat.
  - Stage 1 is the window/line-buffer read; stage 2 is the masked OR.
- Throughput: 1 beat/cycle sustained.
- Input gaps: idle cycles within or between lines are allowed. The output stalls identically, so gaps never change out_data values.
- Vertical blanking:
  - Upstream guarantees >= U_COL+2 idle cycles between the last beat of a frame and the first beat of the next.
  - If blanking is shorter, the violating beats are dropped with err.
- FLUSH to IDLE: the first beat of the next frame is accepted in the cycle after FLUSH ends, at the earliest.
- Simultaneous rst and in_de: rst wins; the beat is discarded.

## Structure
- Shared header constants:
  - State encodings: IDLE=2'd0, STREAM=2'd1, FLUSH=2'd2.
  - Window size WIN=3.
  - The header is shared with erode so both stages agree on encodings.
- Sub-module `mask_line_buffer`:
  - 1-bit, U_COL-deep delay line with an enable.
  - Instantiated twice.
  - Implemented as inferred block RAM with a read-before-write address counter.
- Top level holds the FSM, counters, window, edge masking and output registers.

## Test plan
- Single foreground pixel (U_COL=16, U_ROW=8): pixel at (5,5), contiguous in_de -> ones exactly at rows 4-6, cols 4-6 (9 ones). 128 out_de total; first out_de 2 cycles after input beat 17.
- Corner and edge masking (U_COL=16, U_ROW=8):
  - Pixel at (0,0) -> ones only at (0,0),(0,1),(1,0),(1,1).
  - Pixel at (2,15) -> ones at rows 1-3, cols 14-15 only; col 0 of rows 1-4 stays 0.
- Gapped input: first scenario's pixel with random 0-5 idle cycles between beats -> identical out_data sequence, 128 beats.
- Back-to-back frames: all-zero frame, 18 blanking cycles, all-ones frame -> 128 zeros, then 128 ones, with no err.
- Short blanking: next frame starts 5 cycles into FLUSH -> err pulses for each beat during FLUSH. Remaining bottom-row outputs are still emitted; counters start at the first beat accepted in IDLE.
- Reset mid-frame: rst after 40 beats -> out_de=0 from the next cycle. A following clean frame with a pixel at (5,5) yields the first scenario's result exactly.

Source files
------------

// File: rtl/dilate_pkg.sv
// Constants shared by the erode and dilate mask stages so both agree on encodings.
package dilate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int WIN = 3;

endpackage

// File: rtl/mask_line_buffer.sv
// 1-bit, DEPTH-deep delay line: each enabled beat returns the bit written DEPTH beats earlier.
module mask_line_buffer
    import dilate_pkg::*;
#(
    parameter int DEPTH = 1280
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic din_i,
    output logic dout_o
);
    localparam int AW = $clog2(DEPTH);

    logic          mem_q [DEPTH];
    logic [AW-1:0] addr_q;

    // Read-before-write: the slot about to be overwritten holds the oldest bit.
    assign dout_o = mem_q[addr_q];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_q] <= din_i;
        end
        if (rst) begin
            addr_q <= '0;
        end else if (en_i) begin
            addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        end
    end

endmodule

// File: rtl/dilate.sv
// 3x3 binary dilation of a raster mask stream; zero beats are injected after each frame
// so the bottom row drains. States: IDLE | waiting for pixel (0,0);
// STREAM | accepting frame pixels; FLUSH | injecting U_COL+1 zero beats, input dropped.
module dilate
    import dilate_pkg::*;
#(
    parameter int U_COL = 1280,
    parameter int U_ROW = 720
) (
    input  logic clk,
    input  logic rst,
    input  logic in_de,
    input  logic in_data,
    output logic out_de,
    output logic out_data,
    output logic err
);
    localparam int CW = $clog2(U_COL);
    localparam int RW = $clog2(U_ROW);
    localparam int FW = $clog2(U_COL + 2);
    localparam logic [CW-1:0] COL_LAST   = CW'(U_COL - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(U_ROW - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(U_COL);

    state_e         state_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [FW-1:0]  flush_q;

    logic           beat;
    logic           pix;
    logic           s1_valid_d;
    logic           s1_top_d;
    logic [CW-1:0]  s1_ccol_d;
    logic           lb1_rd;
    logic           lb2_rd;

    logic [WIN-1:0] win0_q;
    logic [WIN-1:0] win1_q;
    logic [WIN-1:0] win2_q;
    logic [CW-1:0]  ccol_q;
    logic           top_q;
    logic           v1_q;
    logic [WIN-1:0] hit_cols;
    logic [WIN-1:0] row_mask;

    logic           out_de_q;
    logic           out_data_q;
    logic           err_q;

    // Centre pixel trails the incoming beat by one line plus one column.
    always_comb begin
        beat       = 1'b0;
        pix        = 1'b0;
        s1_valid_d = 1'b0;
        s1_top_d   = 1'b0;
        s1_ccol_d  = COL_LAST;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    beat = in_de;
                    pix  = in_data;
                end
                STREAM: begin
                    beat       = in_de;
                    pix        = in_data;
                    s1_valid_d = (row_q > RW'(1)) || (row_q == RW'(1) && col_q != '0);
                    s1_top_d   = (row_q == RW'(1) && col_q != '0) || (row_q == RW'(2) && col_q == '0);
                    if (col_q != '0) begin
                        s1_ccol_d = col_q - CW'(1);
                    end
                end
                FLUSH: begin
                    beat       = 1'b1;
                    s1_valid_d = 1'b1;
                    if (flush_q != '0) begin
                        s1_ccol_d = CW'(flush_q - FW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    mask_line_buffer #(.DEPTH(U_COL)) u_lb_prev (
        .clk    (clk),
        .rst    (rst),
        .en_i   (beat),
        .din_i  (pix),
        .dout_o (lb1_rd)
    );

    mask_line_buffer #(.DEPTH(U_COL)) u_lb_prev2 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (beat),
        .din_i  (lb1_rd),
        .dout_o (lb2_rd)
    );

    // Window columns: win0 = right of centre, win1 = centre, win2 = left; bit 2 is the upper row.
    always_ff @(posedge clk) begin
        if (beat) begin
            win0_q <= {lb2_rd, lb1_rd, pix};
            win1_q <= win0_q;
            win2_q <= win1_q;
            ccol_q <= s1_ccol_d;
            top_q  <= s1_top_d;
        end
    end

    assign hit_cols = win1_q
                    | ((ccol_q == COL_LAST) ? '0 : win0_q)
                    | ((ccol_q == '0)       ? '0 : win2_q);
    assign row_mask = {!top_q, 1'b1, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            flush_q    <= '0;
            v1_q       <= 1'b0;
            out_de_q   <= 1'b0;
            out_data_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            v1_q       <= beat && s1_valid_d;
            out_de_q   <= v1_q;
            out_data_q <= v1_q && (|(hit_cols & row_mask));
            err_q      <= (state_q == FLUSH) && in_de;
            case (state_q)
                IDLE: begin
                    if (in_de) begin
                        col_q   <= CW'(1);
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_de) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q   <= '0;
                                flush_q <= '0;
                                state_q <= FLUSH;
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        flush_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        flush_q <= flush_q + FW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_de   = out_de_q;
    assign out_data = out_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dilate.sv
// Bench for dilate on a 16x8 frame; expected output is a direct 3x3 OR over each frame image.
module tb_dilate;
    localparam int C = 16;
    localparam int R = 8;
    localparam int N = C * R;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic in_de   = 1'b0;
    logic in_data = 1'b0;
    logic out_de;
    logic out_data;
    logic err;

    int total         = 0;
    int bad           = 0;
    int cyc           = 0;
    int err_cnt       = 0;
    int first_out_cyc = -1;
    int beat_cyc      = -1;
    bit img [N];
    bit got [$];
    bit exp_q [$];

    dilate #(.U_COL(C), .U_ROW(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_de    (in_de),
        .in_data  (in_data),
        .out_de   (out_de),
        .out_data (out_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_de === 1'b1) begin
            if (got.size() == 0) first_out_cyc = cyc;
            got.push_back(out_data);
        end
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each output pixel is the OR of its in-frame 3x3 neighbourhood.
    function automatic void build_expected();
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                bit v = 1'b0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (r + dr >= 0 && r + dr < R && c + dc >= 0 && c + dc < C)
                            v |= img[(r + dr) * C + c + dc];
                exp_q.push_back(v);
            end
        end
    endfunction

    function automatic int first_diff();
        if (got.size() != exp_q.size())
            return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int count_ones();
        int n = 0;
        foreach (got[i]) n += int'(got[i]);
        return n;
    endfunction

    function automatic void random_img(input int dens);
        foreach (img[i]) img[i] = ($urandom_range(99, 0) < dens);
    endfunction

    task automatic reset_capture();
        got.delete();
        exp_q.delete();
        err_cnt       = 0;
        first_out_cyc = -1;
    endtask

    task automatic drive_frame(input int maxgap);
        int gap;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_de   = 1'b1;
            in_data = img[i];
            if (i == C + 1) beat_cyc = cyc;
            gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            repeat (gap) begin
                @(negedge clk);
                in_de   = 1'b0;
                in_data = 1'($urandom);
            end
        end
        @(negedge clk);
        in_de   = 1'b0;
        in_data = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int k = 0;
        while (got.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (24) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_de = 1'b1; in_data = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_de !== 1'b0) begin bad++; $display("FAIL reset out_de: got %b want 0", out_de); end
        total++; if (out_data !== 1'b0) begin bad++; $display("FAIL reset out_data: got %b want 0", out_data); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", err); end
        rst = 1'b0; in_de = 1'b0; in_data = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (out_de !== 1'b0) begin bad++; $display("FAIL reset idle out_de: got %b want 0", out_de); end
    endtask

    task automatic test_single();
        int d;
        reset_capture();
        img = '{default: 1'b0};
        img[5 * C + 5] = 1'b1;
        build_expected();
        drive_frame(0);
        wait_drain(N);
        total++; if (got.size() != N) begin bad++; $display("FAIL single count: got %0d want %0d", got.size(), N); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL single data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
        total++; if (count_ones() != 9) begin bad++; $display("FAIL single ones: got %0d want 9", count_ones()); end
        total++; if (first_out_cyc - beat_cyc != 2) begin bad++; $display("FAIL single latency: got %0d want 2", first_out_cyc - beat_cyc); end
    endtask

    task automatic test_corners();
        int d;
        reset_capture();
        img = '{default: 1'b0};
        img[0] = 1'b1;
        build_expected();
        drive_frame(0);
        wait_drain(N);
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL corner00 data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
        total++; if (count_ones() != 4) begin bad++; $display("FAIL corner00 ones: got %0d want 4", count_ones()); end

        reset_capture();
        img = '{default: 1'b0};
        img[2 * C + 15] = 1'b1;
        build_expected();
        drive_frame(0);
        wait_drain(N);
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL edge215 data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
        total++; if (count_ones() != 6) begin bad++; $display("FAIL edge215 ones: got %0d want 6", count_ones()); end
    endtask

    task automatic test_gapped();
        int d;
        reset_capture();
        img = '{default: 1'b0};
        img[5 * C + 5] = 1'b1;
        build_expected();
        drive_frame(5);
        wait_drain(N);
        total++; if (got.size() != N) begin bad++; $display("FAIL gapped count: got %0d want %0d", got.size(), N); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL gapped data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d;
        reset_capture();
        img = '{default: 1'b0};
        build_expected();
        drive_frame(0);
        repeat (17) @(negedge clk);
        img = '{default: 1'b1};
        build_expected();
        drive_frame(0);
        wait_drain(2 * N);
        total++; if (got.size() != 2 * N) begin bad++; $display("FAIL b2b count: got %0d want %0d", got.size(), 2 * N); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL b2b data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
        total++; if (err_cnt != 0) begin bad++; $display("FAIL b2b err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_random();
        int d;
        for (int f = 0; f < 3; f++) begin
            reset_capture();
            random_img(10 + 15 * f);
            build_expected();
            drive_frame(f);
            wait_drain(N);
            d = first_diff();
            total++; if (d >= 0) begin bad++; $display("FAIL random%0d data: first diff at beat %0d (got %0d beats, want %0d)", f, d, got.size(), exp_q.size()); end
        end
    endtask

    task automatic test_short_blank();
        int d;
        reset_capture();
        random_img(20);
        build_expected();
        drive_frame(0);
        repeat (4) @(negedge clk);
        // The next 12 beats land in the last 12 flush cycles and must be dropped.
        for (int i = 0; i < C + 1 - 5; i++) begin
            @(negedge clk);
            in_de   = 1'b1;
            in_data = 1'($urandom);
        end
        random_img(30);
        build_expected();
        drive_frame(0);
        wait_drain(2 * N);
        total++; if (err_cnt != C + 1 - 5) begin bad++; $display("FAIL short err: got %0d pulses want %0d", err_cnt, C + 1 - 5); end
        total++; if (got.size() != 2 * N) begin bad++; $display("FAIL short count: got %0d want %0d", got.size(), 2 * N); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL short data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_de   = 1'b1;
            in_data = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; in_de = 1'b1; in_data = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_de = 1'b0; in_data = 1'b0;
        total++; if (out_de !== 1'b0) begin bad++; $display("FAIL midrst out_de: got %b want 0", out_de); end
        @(negedge clk);
        total++; if (out_de !== 1'b0) begin bad++; $display("FAIL midrst pipe: got %b want 0", out_de); end
        repeat (3) @(negedge clk);
        reset_capture();
        img = '{default: 1'b0};
        img[5 * C + 5] = 1'b1;
        build_expected();
        drive_frame(0);
        wait_drain(N);
        total++; if (got.size() != N) begin bad++; $display("FAIL midrst count: got %0d want %0d", got.size(), N); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL midrst data: first diff at beat %0d (got %0d beats, want %0d)", d, got.size(), exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_gapped();
        test_back_to_back();
        test_random();
        test_short_blank();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
